// File: rtl/vga_pkg.sv
// Shared types for the VGA-driven game pipeline: sequencer states, counter widths
// and a small index-width helper.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    FINISH
  } seq_state_t;

  localparam int FRAME_CNT_W = 16;

  // Width of an index that addresses n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing stream as seen by downstream consumers; only vertical blanking is
// carried in this slice.
interface vga_if;
  logic vblnk;

  modport source (output vblnk);
  modport sink   (input  vblnk);
endinterface

// File: rtl/vblnk_edge_det.sv
// Registered edge detector for vblnk. The history register resets high so that
// releasing reset while vblnk is already high never looks like a rising edge.
module vblnk_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_vblnk,
  output logic o_rise,
  output logic o_fall
);

  logic r_vblnk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vblnk_q <= 1'b1;
    end else begin
      r_vblnk_q <= i_vblnk;
    end
  end

  assign o_rise = i_vblnk & ~r_vblnk_q;
  assign o_fall = ~i_vblnk & r_vblnk_q;

endmodule

// File: rtl/frame_sequencer.sv
// Runs the per-frame game-logic stages (start pulse, wait for done) on qualifying
// vblnk rising edges. Define FRAME_SEQ_STATS_EN to add drop_cnt / max_wait outputs.
module frame_sequencer
  import vga_pkg::*;
#(
  parameter int N_STAGES       = 3,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int FRAME_DIV      = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  vga_if.sink                    vga_in,
  input  logic                   enable,
  input  logic [N_STAGES-1:0]    stage_done,
  input  logic                   overrun_clr,
  output logic [N_STAGES-1:0]    stage_start,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   overrun
`ifdef FRAME_SEQ_STATS_EN
  ,
  output logic [7:0]             drop_cnt,
  output logic [15:0]            max_wait
`endif
);

  localparam int K_W = idx_width(N_STAGES);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [K_W-1:0] K_LAST = K_W'(N_STAGES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

  seq_state_t r_state;
  seq_state_t w_state_next;
  logic [K_W-1:0] r_k;
  logic [K_W-1:0] w_k_next;
  logic [TMO_W-1:0] r_tmo;
  logic [TMO_W-1:0] w_tmo_next;
  logic [7:0] r_div;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic r_overrun;

  logic w_rise;
  logic w_fall;
  logic w_qualify;
  logic w_launch;
  logic w_done_hit;
  logic w_timeout;
  logic w_drop;
  logic w_set_ovr;

  vblnk_edge_det u_edge (
    .clk     (clk),
    .rst     (rst),
    .i_vblnk (vga_in.vblnk),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  always_comb begin
    w_state_next = r_state;
    w_k_next     = r_k;
    w_tmo_next   = r_tmo;
    w_done_hit   = 1'b0;
    w_timeout    = 1'b0;
    stage_start  = '0;
    busy         = (r_state != IDLE);
    w_qualify    = (r_state == IDLE) && w_rise && enable;
    w_launch     = w_qualify && (r_div == 8'd0);

    case (r_state)
      IDLE: begin
        if (w_launch) begin
          w_state_next = START;
          w_k_next     = '0;
        end
      end
      START: begin
        stage_start  = N_STAGES'(1) << r_k;
        w_tmo_next   = '0;
        w_state_next = WAIT;
      end
      WAIT: begin
        // Only the current stage's done bit matters; a timeout abandons the rest.
        if (stage_done[r_k]) begin
          w_done_hit = 1'b1;
          if (r_k == K_LAST) begin
            w_state_next = FINISH;
          end else begin
            w_k_next     = r_k + K_W'(1);
            w_state_next = START;
          end
        end else if (r_tmo == TMO_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = FINISH;
        end else begin
          w_tmo_next = r_tmo + TMO_W'(1);
        end
      end
      FINISH: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    w_drop    = busy && w_rise;
    w_set_ovr = w_timeout || w_drop || (busy && w_fall);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_tmo       <= '0;
      r_div       <= 8'd0;
      r_frame_cnt <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_k     <= w_k_next;
      r_tmo   <= w_tmo_next;
      if (w_qualify) begin
        r_div <= (r_div == DIV_LAST) ? 8'd0 : r_div + 8'd1;
      end
      if (r_state == FINISH) begin
        r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
      end
      // A new error in the clearing cycle must not be lost.
      if (w_set_ovr) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign overrun   = r_overrun;

`ifdef FRAME_SEQ_STATS_EN
  logic [7:0] r_drop_cnt;
  logic [15:0] r_max_wait;
  logic [31:0] w_wait_len;
  logic [15:0] w_wait_sat;
  logic w_wait_end;

  // Wait length counts WAIT cycles, including the one in which done arrived.
  assign w_wait_len = 32'(r_tmo) + 32'd1;
  assign w_wait_sat = (w_wait_len > 32'h0000_FFFF) ? 16'hFFFF : w_wait_len[15:0];
  assign w_wait_end = w_done_hit || w_timeout;

  always_ff @(posedge clk) begin
    if (rst || overrun_clr) begin
      r_drop_cnt <= 8'd0;
      r_max_wait <= 16'd0;
    end else begin
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
      if (w_wait_end && (w_wait_sat > r_max_wait)) begin
        r_max_wait <= w_wait_sat;
      end
    end
  end

  assign drop_cnt = r_drop_cnt;
  assign max_wait = r_max_wait;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: a cycle-level behavioural model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_frame_sequencer;

  localparam int N   = 3;
  localparam int TMO = 16;
  localparam int DIV = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic overrun_clr = 1'b0;
  logic [N-1:0] stage_done = '0;
  logic [N-1:0] stage_start;
  logic busy;
  logic [15:0] frame_cnt;
  logic overrun;
`ifdef FRAME_SEQ_STATS_EN
  logic [7:0] drop_cnt;
  logic [15:0] max_wait;
`endif

  vga_if vga ();

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  bit [N-1:0] echo_mask = '0;
  int echo_dly = 5;
  int start_cyc [N];
  int start_cnt [N];
  int busy_first = -1;
  int busy_last = -1;

  // model state
  bit m_prev = 1'b1;
  bit m_active = 1'b0;
  bit m_fin = 1'b0;
  int m_stage = 0;
  int m_age = 0;
  int m_div = 0;
  int m_frames = 0;
  bit m_ovr = 1'b0;
  int m_drops = 0;
  int m_maxw = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  frame_sequencer #(
    .N_STAGES       (N),
    .TIMEOUT_CYCLES (TMO),
    .FRAME_DIV      (DIV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vga_in      (vga),
    .enable      (enable),
    .stage_done  (stage_done),
    .overrun_clr (overrun_clr),
    .stage_start (stage_start),
    .busy        (busy),
    .frame_cnt   (frame_cnt),
    .overrun     (overrun)
`ifdef FRAME_SEQ_STATS_EN
    ,
    .drop_cnt    (drop_cnt),
    .max_wait    (max_wait)
`endif
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // Predicts the next cycle from this cycle's inputs; m_age counts cycles since the
  // current stage's start pulse, so the wait allowance is ages 1..TMO.
  task automatic model_step();
    bit v;
    bit rise;
    bit fall;
    bit set_o;
    if (rst) begin
      m_prev = 1'b1; m_active = 1'b0; m_fin = 1'b0; m_stage = 0; m_age = 0;
      m_div = 0; m_frames = 0; m_ovr = 1'b0; m_drops = 0; m_maxw = 0;
      return;
    end
    v = vga.vblnk;
    rise = v && !m_prev;
    fall = !v && m_prev;
    m_prev = v;
    set_o = m_active && (rise || fall);
    if (m_active && rise && m_drops < 255) m_drops++;
    if (!m_active) begin
      if (rise && enable) begin
        if (m_div == 0) begin
          m_active = 1'b1; m_stage = 0; m_age = 0; m_fin = 1'b0;
        end
        m_div = (m_div + 1) % DIV;
      end
    end else if (m_fin) begin
      m_active = 1'b0;
      m_fin = 1'b0;
      m_frames = (m_frames + 1) % 65536;
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (stage_done[m_stage]) begin
      if (m_age > m_maxw) m_maxw = m_age;
      if (m_stage == N - 1) m_fin = 1'b1;
      else begin
        m_stage++;
        m_age = 0;
      end
    end else if (m_age == TMO) begin
      set_o = 1'b1;
      m_fin = 1'b1;
      if (m_age > m_maxw) m_maxw = m_age;
    end else begin
      m_age++;
    end
    if (set_o) m_ovr = 1'b1;
    else if (overrun_clr) m_ovr = 1'b0;
    if (overrun_clr) begin
      m_drops = 0;
      m_maxw = 0;
    end
  endtask

  // compare process: outputs are stable at the falling edge
  initial begin
    logic [31:0] es;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        es = (m_active && !m_fin && m_age == 0) ? (32'd1 << m_stage) : 32'd0;
        chk("stage_start", 32'(stage_start), es);
        chk("busy", 32'(busy), 32'(m_active));
        chk("frame_cnt", 32'(frame_cnt), m_frames);
        chk("overrun", 32'(overrun), 32'(m_ovr));
`ifdef FRAME_SEQ_STATS_EN
        chk("drop_cnt", 32'(drop_cnt), m_drops);
        chk("max_wait", 32'(max_wait), m_maxw);
`endif
      end
      for (int i = 0; i < N; i++) begin
        if (stage_start[i] === 1'b1) begin
          start_cyc[i] = cyc;
          start_cnt[i]++;
        end
      end
      if (busy === 1'b1) begin
        if (busy_first < 0) busy_first = cyc;
        busy_last = cyc;
      end
      model_step();
    end
  end

  // game-logic stand-in: echoes done echo_dly cycles after each enabled start
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        stage_done[i] = echo_mask[i] && (cyc == start_cyc[i] + echo_dly);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_rst();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      start_cyc[i] = -100;
      start_cnt[i] = 0;
    end
    busy_first = -1;
    busy_last = -1;
  endtask

  initial begin
    int r;
    int r2;
    int exp_cnt [6] = '{1, 1, 1, 2, 2, 2};
    int rise_c [6];
    vga.vblnk = 1'b0;
    for (int i = 0; i < N; i++) begin
      start_cyc[i] = -100;
      start_cnt[i] = 0;
    end

    // 1: full three-stage sequence, done echoed 5 cycles after each start
    do_rst();
    chk("rst_stage_start", 32'(stage_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    chk("rst_overrun", 32'(overrun), 0);
    enable = 1'b1;
    echo_mask = 3'b111;
    echo_dly = 5;
    step();
    step();
    r = cyc;
    vga.vblnk = 1'b1;
    run_to(r + 30);
    chk("t1_start0_cyc", start_cyc[0], r + 1);
    chk("t1_start1_cyc", start_cyc[1], r + 7);
    chk("t1_start2_cyc", start_cyc[2], r + 13);
    chk("t1_busy_first", busy_first, r + 1);
    chk("t1_busy_last", busy_last, r + 19);
    chk("t1_frame_cnt", 32'(frame_cnt), 1);
    chk("t1_overrun", 32'(overrun), 0);
    vga.vblnk = 1'b0;
    step();

    // 2: stage 1 never completes -> timeout, stage 2 skipped
    do_rst();
    echo_mask = 3'b101;
    step();
    r = cyc;
    vga.vblnk = 1'b1;
    run_to(r + 7 + 15);
    chk("t2_start1_cyc", start_cyc[1], r + 7);
    chk("t2_overrun_early", 32'(overrun), 0);
    run_to(r + 7 + 17);
    chk("t2_overrun_set", 32'(overrun), 1);
    run_to(r + 40);
    chk("t2_stage2_starts", start_cnt[2], 0);
    chk("t2_frame_cnt", 32'(frame_cnt), 1);
    chk("t2_busy", 32'(busy), 0);
    vga.vblnk = 1'b0;
    step();

    // 3: divide by 3 -> sequences on rises 1 and 4
    do_rst();
    echo_mask = 3'b111;
    echo_dly = 1;
    for (int k = 0; k < 6; k++) begin
      step();
      rise_c[k] = cyc;
      vga.vblnk = 1'b1;
      run_to(cyc + 12);
      vga.vblnk = 1'b0;
      run_to(cyc + 4);
      chk("t3_launch_count", start_cnt[0], exp_cnt[k]);
      if (k == 0) chk("t3_first_launch", start_cyc[0], rise_c[0] + 1);
    end
    chk("t3_last_launch", start_cyc[0], rise_c[3] + 1);
    chk("t3_frame_cnt", 32'(frame_cnt), 2);

    // 4: stage 0 stalls across the next rise -> dropped frame, no relaunch
    do_rst();
    echo_mask = 3'b000;
    step();
    r = cyc;
    vga.vblnk = 1'b1;
    run_to(r + 3);
    vga.vblnk = 1'b0;
    run_to(r + 4);
    overrun_clr = 1'b1;
    chk("t4_fall_overrun", 32'(overrun), 1);
    run_to(r + 5);
    overrun_clr = 1'b0;
    chk("t4_clr_alone", 32'(overrun), 0);
    run_to(r + 6);
    vga.vblnk = 1'b1;
    run_to(r + 7);
    chk("t4_drop_overrun", 32'(overrun), 1);
    run_to(r + 40);
    chk("t4_launches", start_cnt[0], 1);
    chk("t4_frame_cnt", 32'(frame_cnt), 1);
    chk("t4_busy", 32'(busy), 0);
`ifdef FRAME_SEQ_STATS_EN
    chk("t4_drop_cnt", 32'(drop_cnt), 1);
    chk("t4_max_wait", 32'(max_wait), 16);
`endif
    vga.vblnk = 1'b0;
    step();

    // 5: reset during stage 1 wait, then a clean restart
    do_rst();
    echo_mask = 3'b101;
    echo_dly = 5;
    step();
    r = cyc;
    vga.vblnk = 1'b1;
    run_to(r + 10);
    rst = 1'b1;
    run_to(r + 11);
    rst = 1'b0;
    chk("t5_rst_stage_start", 32'(stage_start), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_frame_cnt", 32'(frame_cnt), 0);
    chk("t5_rst_overrun", 32'(overrun), 0);
    run_to(r + 14);
    vga.vblnk = 1'b0;
    echo_mask = 3'b111;
    run_to(r + 17);
    chk("t5_no_stray_pulse", start_cnt[1], 1);
    r2 = cyc;
    vga.vblnk = 1'b1;
    run_to(r2 + 30);
    chk("t5_restart_stage0", start_cyc[0], r2 + 1);
    chk("t5_stage2_once", start_cnt[2], 1);
    chk("t5_frame_cnt", 32'(frame_cnt), 1);
    vga.vblnk = 1'b0;
    step();

    // 6: clear colliding with a timeout keeps the flag; a lone clear drops it
    do_rst();
    echo_mask = 3'b000;
    step();
    r = cyc;
    vga.vblnk = 1'b1;
    run_to(r + 17);
    overrun_clr = 1'b1;
    chk("t6_before_timeout", 32'(overrun), 0);
    run_to(r + 18);
    overrun_clr = 1'b0;
    chk("t6_set_wins", 32'(overrun), 1);
    run_to(r + 25);
    vga.vblnk = 1'b0;
    overrun_clr = 1'b1;
    run_to(r + 26);
    overrun_clr = 1'b0;
    chk("t6_clear", 32'(overrun), 0);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
